calf_inject_port: RTL and testbench



---
 rtl/calf_inject_port_pkg.sv | 36 +++
 rtl/calf_inj_fifo.sv | 58 +++++
 rtl/calf_inject_port.sv | 169 ++++++++++++++++
 tb/tb_calf_inject_port.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/calf_inject_port_pkg.sv
// Shared widths, control-word layout and FSM encodings for the CALF injection port.
package calf_inject_port_pkg;

  localparam int DEST_W = 4;
  localparam int DATA_W = 32;
  localparam int AGE_W  = 3;

  // Control word is {valid, age, seq, src, dest}, dest in the LSBs.
  localparam int DEST_LSB = 0;
  localparam int SRC_LSB  = DEST_W;
  localparam int SEQ_LSB  = 2 * DEST_W;

  function automatic int age_lsb(input int seq_w);
    return SEQ_LSB + seq_w;
  endfunction

  function automatic int valid_bit(input int seq_w);
    return SEQ_LSB + seq_w + AGE_W;
  endfunction

  function automatic int control_w(input int seq_w);
    return valid_bit(seq_w) + 1;
  endfunction

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_WAITING = 2'd1,
    ST_STARVED = 2'd2
  } inj_state_e;

  typedef struct packed {
    logic [DEST_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } inj_flit_t;

endpackage

// File: rtl/calf_inj_fifo.sv
// DEPTH-entry synchronous FIFO; head is visible combinationally, push blocked when full.
module calf_inj_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int OCC_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     wdata,
  output logic [W-1:0]     head,
  output logic [OCC_W-1:0] occupancy,
  output logic             full,
  output logic             empty
);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             do_push, do_pop;

  assign full    = (occ_q == OCC_W'(DEPTH));
  assign empty   = (occ_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    occ_d = occ_q + OCC_W'(do_push) - OCC_W'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage needs no reset: pointers and occupancy define what is live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

  assign head      = mem[rd_ptr_q];
  assign occupancy = occ_q;

endmodule

// File: rtl/calf_inject_port.sv
// Injection stage feeding the CALF router local port: stamps src/seq/age and flags head starvation.
// Optional INJ_STATS_EN adds inj_count and max_wait statistics outputs.
module calf_inject_port
  import calf_inject_port_pkg::*;
#(
  parameter int NODE_ID      = 0,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 16,
  parameter int SEQ_W        = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_valid,
  input  logic [DEST_W-1:0]           req_dest,
  input  logic [DATA_W-1:0]           req_data,
  output logic                        req_ready,
  input  logic                        inj_free,
  output logic [control_w(SEQ_W)-1:0] port_co,
  output logic [DATA_W-1:0]           port_do,
  output logic                        starved,
  output logic [$clog2(DEPTH):0]      occupancy
`ifdef INJ_STATS_EN
  ,
  output logic [31:0]                 inj_count,
  output logic [15:0]                 max_wait
`endif
);

  localparam int OCC_W  = $clog2(DEPTH) + 1;
  localparam int WCNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [WCNT_W-1:0] LIMIT  = WCNT_W'(STARVE_LIMIT);
  localparam logic [DEST_W-1:0] SRC_ID = DEST_W'(NODE_ID);

  typedef struct packed {
    logic              valid;
    logic [AGE_W-1:0]  age;
    logic [SEQ_W-1:0]  seq;
    logic [DEST_W-1:0] src;
    logic [DEST_W-1:0] dest;
  } ctrl_t;

  inj_flit_t        wflit, head;
  logic             full, empty, push, pop;
  logic [OCC_W-1:0] occ, occ_next;

  ctrl_t             ctrl_q, ctrl_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [SEQ_W-1:0]  seq_q, seq_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  inj_state_e        state_q, state_d;

  assign wflit.dest = req_dest;
  assign wflit.data = req_data;

  calf_inj_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(inj_flit_t))
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .wdata     (wflit),
    .head      (head),
    .occupancy (occ),
    .full      (full),
    .empty     (empty)
  );

  // Ready comes from registered occupancy only, so a full FIFO refuses even on a pop cycle.
  assign req_ready = !full;
  assign push      = req_valid && !full;
  assign pop       = !empty && inj_free;
  assign occ_next  = occ + OCC_W'(push) - OCC_W'(pop);
  assign occupancy = occ;

  always_comb begin
    ctrl_d = '0;
    data_d = data_q;
    seq_d  = seq_q;
    if (pop) begin
      ctrl_d.valid = 1'b1;
      ctrl_d.age   = '0;
      ctrl_d.seq   = seq_q;
      ctrl_d.src   = SRC_ID;
      ctrl_d.dest  = head.dest;
      data_d       = head.data;
      seq_d        = seq_q + 1'b1;
    end
  end

  always_comb begin
    wcnt_d = wcnt_q;
    if (pop) wcnt_d = '0;
    else if (!empty && !inj_free && wcnt_q != LIMIT) wcnt_d = wcnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q  <= '0;
      data_q  <= '0;
      seq_q   <= '0;
      wcnt_q  <= '0;
      state_q <= ST_EMPTY;
    end else begin
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
      seq_q   <= seq_d;
      wcnt_q  <= wcnt_d;
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_EMPTY: if (push) state_d = ST_WAITING;
      ST_WAITING, ST_STARVED: begin
        if (pop)                  state_d = (occ_next == '0) ? ST_EMPTY : ST_WAITING;
        else if (wcnt_d == LIMIT) state_d = ST_STARVED;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_comb begin
    starved = 1'b0;
    if (state_q == ST_STARVED) starved = 1'b1;
  end

  assign port_co = ctrl_q;
  assign port_do = data_q;

`ifdef INJ_STATS_EN
  logic [31:0] inj_cnt_q, inj_cnt_d;
  logic [15:0] wraw_q, wraw_d;
  logic [15:0] maxw_q, maxw_d;

  // Unsaturated twin of the wait counter, so max_wait can exceed STARVE_LIMIT.
  always_comb begin
    inj_cnt_d = inj_cnt_q;
    wraw_d    = wraw_q;
    maxw_d    = maxw_q;
    if (pop) begin
      inj_cnt_d = inj_cnt_q + 32'd1;
      wraw_d    = '0;
      if (wraw_q > maxw_q) maxw_d = wraw_q;
    end else if (!empty && !inj_free && wraw_q != 16'hFFFF) begin
      wraw_d = wraw_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inj_cnt_q <= '0;
      wraw_q    <= '0;
      maxw_q    <= '0;
    end else begin
      inj_cnt_q <= inj_cnt_d;
      wraw_q    <= wraw_d;
      maxw_q    <= maxw_d;
    end
  end

  assign inj_count = inj_cnt_q;
  assign max_wait  = maxw_q;
`endif

endmodule

// File: tb/tb_calf_inject_port.sv
// Directed bench for calf_inject_port with a queue-based reference model checked every cycle.
module tb_calf_inject_port;

  localparam int DEPTH = 4;
  localparam int LIMIT = 16;
  localparam int NODE  = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [3:0]  req_dest = '0;
  logic [31:0] req_data = '0;
  logic        req_ready;
  logic        inj_free = 1'b0;
  logic [19:0] port_co;
  logic [31:0] port_do;
  logic        starved;
  logic [2:0]  occupancy;
`ifdef INJ_STATS_EN
  logic [31:0] inj_count;
  logic [15:0] max_wait;
`endif

  int tests = 0;
  int fails = 0;
  int sent  = 0;
  int seen  = 0;

  calf_inject_port #(
    .NODE_ID      (NODE),
    .DEPTH        (DEPTH),
    .STARVE_LIMIT (LIMIT),
    .SEQ_W        (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_dest  (req_dest),
    .req_data  (req_data),
    .req_ready (req_ready),
    .inj_free  (inj_free),
    .port_co   (port_co),
    .port_do   (port_do),
    .starved   (starved),
    .occupancy (occupancy)
`ifdef INJ_STATS_EN
    ,
    .inj_count (inj_count),
    .max_wait  (max_wait)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of pending flits plus counters of pops and denied cycles.
  typedef struct {
    logic [3:0]  dest;
    logic [31:0] data;
  } flit_t;

  flit_t       mq[$];
  int          pops   = 0;
  int          denied = 0;
  logic        e_v    = 1'b0;
  logic [3:0]  e_dest = '0;
  logic [7:0]  e_seq  = '0;
  logic [31:0] e_data = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      pops   = 0;
      denied = 0;
      e_v    = 1'b0;
      e_data = '0;
    end else begin : model_step
      bit    rdy, pp, ps;
      flit_t f;
      rdy = (mq.size() != DEPTH);
      pp  = (mq.size() != 0) && inj_free;
      ps  = req_valid && rdy;
      if (pp) begin
        f      = mq.pop_front();
        e_v    = 1'b1;
        e_dest = f.dest;
        e_data = f.data;
        e_seq  = 8'(pops);
        pops++;
        denied = 0;
      end else begin
        e_v = 1'b0;
        if (mq.size() != 0 && !inj_free) denied++;
      end
      if (ps) mq.push_back('{dest: req_dest, data: req_data});
    end
    #1;
    check("occupancy", 64'(occupancy), 64'(mq.size()));
    check("req_ready", 64'(req_ready), 64'(mq.size() != DEPTH));
    check("starved",   64'(starved),   64'(denied >= LIMIT));
    check("co_valid",  64'(port_co[19]), 64'(e_v));
    check("port_do",   64'(port_do),   64'(e_data));
    if (e_v) begin
      check("co_dest", 64'(port_co[3:0]),   64'(e_dest));
      check("co_src",  64'(port_co[7:4]),   64'(NODE));
      check("co_seq",  64'(port_co[15:8]),  64'(e_seq));
      check("co_age",  64'(port_co[18:16]), 64'(0));
    end
  end

  task automatic do_reset();
    req_valid = 1'b0;
    inj_free  = 1'b0;
    rst_n     = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset, then idle
    repeat (3) @(negedge clk);
    check("rst_valid",   64'(port_co[19]), 64'(0));
    check("rst_do",      64'(port_do),     64'(0));
    check("rst_starved", 64'(starved),     64'(0));
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_occ",   64'(occupancy),   64'(0));
    check("idle_ready", 64'(req_ready),   64'(1));
    check("idle_valid", 64'(port_co[19]), 64'(0));

    // Single flit
    inj_free  = 1'b1;
    req_valid = 1'b1;
    req_dest  = 4'd3;
    req_data  = 32'hA5;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("one_valid", 64'(port_co[19]),    64'(1));
    check("one_seq",   64'(port_co[15:8]),  64'(0));
    check("one_src",   64'(port_co[7:4]),   64'(5));
    check("one_dest",  64'(port_co[3:0]),   64'(3));
    check("one_age",   64'(port_co[18:16]), 64'(0));
    check("one_do",    64'(port_do),        64'(32'hA5));
    check("one_occ",   64'(occupancy),      64'(0));

    // Fill to full with the router busy, then drain in order
    do_reset();
    inj_free = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1;
      req_dest  = 4'(i + 8);
      req_data  = 32'h100 + 32'(i);
      if (i == 4) check("full_ready", 64'(req_ready), 64'(0));
      @(negedge clk);
    end
    check("full_occ", 64'(occupancy), 64'(4));
    req_valid = 1'b0;
    inj_free  = 1'b1;
    @(negedge clk);
    check("drain0_seq",  64'(port_co[15:8]), 64'(0));
    check("drain0_dest", 64'(port_co[3:0]),  64'(8));
    check("drain0_do",   64'(port_do),       64'(32'h100));
    repeat (3) @(negedge clk);
    check("drain3_seq",  64'(port_co[15:8]), 64'(3));
    check("drain3_dest", 64'(port_co[3:0]),  64'(11));
    check("drain3_do",   64'(port_do),       64'(32'h103));
    @(negedge clk);
    check("drain_occ",   64'(occupancy),   64'(0));
    check("drain_idle",  64'(port_co[19]), 64'(0));
    check("drain_hold",  64'(port_do),     64'(32'h103));

    // Starvation
    do_reset();
    req_valid = 1'b1;
    req_dest  = 4'd2;
    req_data  = 32'hBEEF;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (15) @(negedge clk);
    check("starve_15", 64'(starved), 64'(0));
    @(negedge clk);
    check("starve_16", 64'(starved), 64'(1));
    inj_free = 1'b1;
    @(negedge clk);
    check("starve_clr",   64'(starved),     64'(0));
    check("starve_valid", 64'(port_co[19]), 64'(1));
    check("starve_do",    64'(port_do),     64'(32'hBEEF));

    // Sequence wrap over 257 back-to-back flits
    do_reset();
    inj_free = 1'b1;
    sent = 0;
    seen = 0;
    for (int c = 0; c < 300 && seen < 257; c++) begin
      req_valid = (sent < 257);
      req_dest  = 4'(sent);
      req_data  = 32'h1000 + 32'(sent);
      if (req_valid) sent++;
      @(negedge clk);
      if (port_co[19]) begin
        seen++;
        if (seen == 256) check("wrap_255", 64'(port_co[15:8]), 64'(255));
        if (seen == 257) check("wrap_0",   64'(port_co[15:8]), 64'(0));
      end
    end
    req_valid = 1'b0;
    check("wrap_count", 64'(seen), 64'(257));

    // Asynchronous reset between edges with flits queued
    inj_free = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1;
      req_dest  = 4'(i + 1);
      req_data  = 32'h2000 + 32'(i);
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("pre_rst_occ", 64'(occupancy), 64'(3));
    check("pre_rst_do",  64'(port_do),   64'(32'h1100));
    #2 rst_n = 1'b0;
    #1;
    check("arst_occ",     64'(occupancy),   64'(0));
    check("arst_do",      64'(port_do),     64'(0));
    check("arst_valid",   64'(port_co[19]), 64'(0));
    check("arst_ready",   64'(req_ready),   64'(1));
    check("arst_starved", 64'(starved),     64'(0));
    #1 rst_n = 1'b1;
    @(negedge clk);
    inj_free  = 1'b1;
    req_valid = 1'b1;
    req_dest  = 4'd7;
    req_data  = 32'h77;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("post_rst_valid", 64'(port_co[19]),   64'(1));
    check("post_rst_seq",   64'(port_co[15:8]), 64'(0));
    check("post_rst_dest",  64'(port_co[3:0]),  64'(7));
    check("post_rst_do",    64'(port_do),       64'(32'h77));
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
